bg_rom_arbiter: RTL and testbench
=================================

BG_ROM_ARBITER -- requirements
Module: bg_rom_arbiter

Interface
REQ-001 SHALL have parameter IMG_W, default 320, background width in pixels.
REQ-002 SHALL have parameter IMG_H, default 240, background height in pixels.
REQ-003 SHALL have parameter MAX_WAIT, default 8, consecutive denied game cycles before a forced game slot.
REQ-004 SHALL have port Clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port Reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port vga_req  in  1  pixel fetch request, single cycle, no handshake.
REQ-007 SHALL have port vga_x  in  10  pixel column.
REQ-008 SHALL have port vga_y  in  9  pixel row.
REQ-009 SHALL have port vga_valid  out  1  vga_data carries a fresh result.
REQ-010 SHALL have port vga_data  out  5  palette index for the VGA requester.
REQ-011 SHALL have port game_req  in  1  game-logic lookup request, held until acked.
REQ-012 SHALL have port game_x  in  10  lookup column, stable while game_req is high.
REQ-013 SHALL have port game_y  in  9  lookup row, stable while game_req is high.
REQ-014 SHALL have port game_ack  out  1  one-cycle grant pulse.
REQ-015 SHALL have port game_valid  out  1  game_data/game_oob valid, one-cycle pulse.
REQ-016 SHALL have port game_data  out  5  palette index for the game requester.
REQ-017 SHALL have port game_oob  out  1  game lookup coordinate was out of range.
REQ-018 SHALL have port rom_addr  out  18  read address to the synchronous background ROM.
REQ-019 SHALL have port rom_data  in  5  ROM output, valid one cycle after rom_addr.

Function
REQ-020 SHALL compute the address as y*IMG_W+x with 18-bit result; at the default width, use shift-add (y<<8)+(y<<6)+x; max 76799.
REQ-021 SHALL treat a coordinate as out of range when x>=IMG_W or y>=IMG_H; an out-of-range request never drives rom_addr.
REQ-022 SHALL grant per cycle: an in-range vga_req wins unless the forced-slot condition holds; otherwise a pending in-range game_req wins.
REQ-023 SHALL drive rom_addr combinationally from the granted request; with no grant, rom_addr holds its previous value.
REQ-024 SHALL assert game_ack in the grant cycle; game_valid with game_data=rom_data follows exactly one cycle later.
REQ-025 SHALL assert vga_valid with vga_data=rom_data exactly one cycle after a granted vga_req.
REQ-026 SHALL treat an out-of-range vga_req as a non-consuming slot: vga_valid=1 and vga_data=0 next cycle, and the ROM is free for game that cycle.
REQ-027 SHALL ack an out-of-range game_req immediately, regardless of VGA: game_valid=1, game_data=0, game_oob=1 next cycle.
REQ-028 SHALL use a wait counter that increments each cycle game_req is high, in range, and denied; it resets to 0 on game_ack or when game_req is low.
REQ-029 SHALL force a game grant when the wait counter equals MAX_WAIT, even if vga_req is high; the counter returns to 0.
REQ-030 SHALL respond to a VGA request displaced by a forced slot with vga_valid=0 next cycle, with vga_data holding its last value (repeated pixel).
REQ-031 SHALL implement the game FSM IDLE -> WAIT (req denied) -> ISSUE (ack) -> RESP (valid) -> IDLE; a grant from IDLE goes directly to ISSUE.
REQ-032 SHALL not sample a new game_req in the cycle game_valid is high; back-to-back lookups therefore take at least 2 cycles each.
REQ-033 SHALL hold vga_data and game_data between valid pulses; valid outputs are single-cycle pulses.

Reset
REQ-034 SHALL, while Reset_n=0, force all outputs to 0, set the FSM to IDLE, and set the wait counter to 0.
REQ-035 SHALL, on reset during ISSUE/RESP, drop the in-flight response (no valid after release); the requester must re-request.

Verification
REQ-036 SHALL cover: vga_req=1, (x,y)=(5,2) -> rom_addr=645 same cycle; vga_valid=1 next cycle with vga_data=rom_data.
REQ-037 SHALL cover: game_req=1, (319,239) with VGA idle -> game_ack same cycle, rom_addr=76799; game_valid next cycle.
REQ-038 SHALL cover: vga_req held high, game_req high in range -> ack after exactly 8 denied cycles; that slot's vga_valid=0 and vga_data unchanged.
REQ-039 SHALL cover: game_req=1, (320,0) with vga_req=1 -> immediate ack; next cycle game_oob=1, game_data=0; VGA unaffected.
REQ-040 SHALL cover: Reset_n low for 1 cycle in the cycle after game_ack -> no game_valid; all outputs 0; FSM IDLE.
REQ-041 SHALL cover: vga_req=1 at (400,10) with game_req pending -> game granted same cycle; vga_valid=1 with vga_data=0 next cycle.

Source files
------------

// File: rtl/bg_rom_arbiter.sv
// Arbitrates one synchronous background ROM between a VGA pixel fetcher (priority)
// and a game-logic lookup port with bounded-wait starvation protection.
module bg_rom_arbiter #(
   parameter int IMG_W    = 320,
   parameter int IMG_H    = 240,
   parameter int MAX_WAIT = 8
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        vga_req,
   input  logic [9:0]  vga_x,
   input  logic [8:0]  vga_y,
   output logic        vga_valid,
   output logic [4:0]  vga_data,
   input  logic        game_req,
   input  logic [9:0]  game_x,
   input  logic [8:0]  game_y,
   output logic        game_ack,
   output logic        game_valid,
   output logic [4:0]  game_data,
   output logic        game_oob,
   output logic [17:0] rom_addr,
   input  logic [4:0]  rom_data
);

   localparam int          CW    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [10:0] W_LIM = 11'(IMG_W);
   localparam logic [9:0]  H_LIM = 10'(IMG_H);
   localparam logic [CW-1:0] MAX_W = CW'(MAX_WAIT);

   typedef enum logic [1:0] {IDLE, WAIT, ISSUE, RESP} game_st_e;

   game_st_e        state_q, state_d, cur_st;
   logic [CW-1:0]   wait_q, wait_d;
   logic            vga_pend_q, vga_oob_q;
   logic [4:0]      vga_hold_q, game_hold_q;
   logic            game_oob_q, game_oob_d;
   logic [17:0]     addr_q;

   logic            vga_inr, game_inr, g_live, g_oob, forced, vga_win, game_win;
   logic [17:0]     vga_lin, game_lin;

   function automatic logic [17:0] lin_addr(input logic [9:0] x, input logic [8:0] y);
      logic [17:0] yy;
      yy = {9'd0, y};
      if (IMG_W == 320)
         return (yy << 8) + (yy << 6) + {8'd0, x};
      else
         return 18'(yy * 18'(IMG_W)) + {8'd0, x};
   endfunction

   always_comb begin
      vga_inr  = ({1'b0, vga_x} < W_LIM) && ({1'b0, vga_y} < H_LIM);
      game_inr = ({1'b0, game_x} < W_LIM) && ({1'b0, game_y} < H_LIM);
      vga_lin  = lin_addr(vga_x, vga_y);
      game_lin = lin_addr(game_x, game_y);

      // The response cycle is not a sampling opportunity for a new lookup.
      g_live   = Reset_n && game_req && (state_q != RESP);
      g_oob    = g_live && !game_inr;
      forced   = g_live && game_inr && (wait_q == MAX_W);
      vga_win  = Reset_n && vga_req && vga_inr && !forced;
      game_win = g_live && game_inr && !vga_win;
      game_ack = game_win || g_oob;

      if (!Reset_n)      rom_addr = '0;
      else if (vga_win)  rom_addr = vga_lin;
      else if (game_win) rom_addr = game_lin;
      else               rom_addr = addr_q;

      wait_d = '0;
      if (g_live && game_inr && !game_win) wait_d = wait_q + 1'b1;

      game_oob_d = game_ack ? g_oob : game_oob_q;
   end

   // A grant turns the current cycle into ISSUE regardless of IDLE/WAIT.
   always_comb begin
      cur_st  = game_ack ? ISSUE : state_q;
      state_d = cur_st;
      case (cur_st)
         IDLE:    state_d = (g_live && game_inr) ? WAIT : IDLE;
         WAIT:    state_d = game_req ? WAIT : IDLE;
         ISSUE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      vga_valid = vga_pend_q || vga_oob_q;
      if (vga_pend_q)     vga_data = rom_data;
      else if (vga_oob_q) vga_data = '0;
      else                vga_data = vga_hold_q;

      game_valid = (state_q == RESP);
      if (game_valid) game_data = game_oob_q ? 5'd0 : rom_data;
      else            game_data = game_hold_q;
      game_oob = game_oob_q;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         vga_pend_q  <= 1'b0;
         vga_oob_q   <= 1'b0;
         vga_hold_q  <= '0;
         game_hold_q <= '0;
         game_oob_q  <= 1'b0;
         addr_q      <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         vga_pend_q  <= vga_win;
         vga_oob_q   <= vga_req && !vga_inr;
         vga_hold_q  <= vga_data;
         game_hold_q <= game_data;
         game_oob_q  <= game_oob_d;
         addr_q      <= rom_addr;
      end
   end

endmodule

// File: tb/tb_bg_rom_arbiter.sv
// Directed bench for bg_rom_arbiter: stimulus pushes expected responses, a negedge
// monitor pops them whenever vga_valid/game_valid pulse.
module tb_bg_rom_arbiter;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        vga_req;
   logic [9:0]  vga_x;
   logic [8:0]  vga_y;
   logic        vga_valid;
   logic [4:0]  vga_data;
   logic        game_req;
   logic [9:0]  game_x;
   logic [8:0]  game_y;
   logic        game_ack;
   logic        game_valid;
   logic [4:0]  game_data;
   logic        game_oob;
   logic [17:0] rom_addr;
   logic [4:0]  rom_data = '0;

   int total = 0;
   int bad   = 0;

   logic [4:0] vq[$];
   logic [5:0] gq[$];

   bg_rom_arbiter #(.IMG_W(320), .IMG_H(240), .MAX_WAIT(8)) dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .vga_req(vga_req), .vga_x(vga_x), .vga_y(vga_y),
      .vga_valid(vga_valid), .vga_data(vga_data),
      .game_req(game_req), .game_x(game_x), .game_y(game_y),
      .game_ack(game_ack), .game_valid(game_valid), .game_data(game_data),
      .game_oob(game_oob), .rom_addr(rom_addr), .rom_data(rom_data)
   );

   always #5 Clk = ~Clk;

   function automatic logic [4:0] romf(input logic [17:0] a);
      logic [17:0] t;
      t = a ^ (a >> 5) ^ (a >> 11);
      return t[4:0];
   endfunction

   always @(posedge Clk) rom_data <= romf(rom_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge Clk) begin
      if (vga_valid === 1'b1) begin
         if (vq.size() == 0) chk("vga_unexpected_valid", 32'd1, 32'd0);
         else chk("vga_data", {27'd0, vga_data}, {27'd0, vq.pop_front()});
      end
      if (game_valid === 1'b1) begin
         if (gq.size() == 0) chk("game_unexpected_valid", 32'd1, 32'd0);
         else chk("game_oob_data", {26'd0, game_oob, game_data}, {26'd0, gq.pop_front()});
      end
   end

   task automatic step(input logic vr, input int vx, input int vy,
                       input logic gr, input int gx, input int gy);
      @(posedge Clk);
      #1;
      vga_req  = vr;  vga_x  = 10'(vx); vga_y  = 9'(vy);
      game_req = gr;  game_x = 10'(gx); game_y = 9'(gy);
      @(negedge Clk);
   endtask

   initial begin
      Reset_n = 1'b0;
      vga_req = 1'b0; vga_x = '0; vga_y = '0;
      game_req = 1'b0; game_x = '0; game_y = '0;
      repeat (2) @(negedge Clk);
      chk("reset_outputs", {vga_valid, vga_data, game_ack, game_valid, game_data, game_oob, rom_addr}, 32'd0);
      @(posedge Clk); #1 Reset_n = 1'b1;

      // VGA pixel (5,2) -> 645
      step(1, 5, 2, 0, 0, 0);
      chk("vga_addr_5_2", {14'd0, rom_addr}, 32'd645);
      vq.push_back(romf(18'd645));
      step(0, 0, 0, 0, 0, 0);

      // Game corner pixel (319,239) -> 76799
      step(0, 0, 0, 1, 319, 239);
      chk("game_ack_corner", {31'd0, game_ack}, 32'd1);
      chk("game_addr_corner", {14'd0, rom_addr}, 32'd76799);
      gq.push_back({1'b0, romf(18'd76799)});
      step(0, 0, 0, 0, 0, 0);
      chk("addr_hold_no_grant", {14'd0, rom_addr}, 32'd76799);

      // Out-of-range VGA frees the slot for a pending game lookup (3,1) -> 323
      step(1, 400, 10, 1, 3, 1);
      chk("game_ack_vga_oob", {31'd0, game_ack}, 32'd1);
      chk("game_addr_vga_oob", {14'd0, rom_addr}, 32'd323);
      vq.push_back(5'd0);
      gq.push_back({1'b0, romf(18'd323)});
      step(0, 0, 0, 0, 0, 0);

      // Out-of-range game lookup acked immediately while VGA (7,3) -> 967 proceeds
      step(1, 7, 3, 1, 320, 0);
      chk("game_ack_oob", {31'd0, game_ack}, 32'd1);
      chk("vga_addr_7_3", {14'd0, rom_addr}, 32'd967);
      vq.push_back(romf(18'd967));
      gq.push_back({1'b1, 5'd0});
      step(0, 0, 0, 0, 0, 0);

      // Starvation: 8 denied cycles, then forced slot for (10,20) -> 6410
      for (int i = 0; i < 8; i++) begin
         step(1, i, 0, 1, 10, 20);
         chk("denied_no_ack", {31'd0, game_ack}, 32'd0);
         chk("vga_addr_row0", {14'd0, rom_addr}, i);
         vq.push_back(romf(18'(i)));
      end
      step(1, 8, 0, 1, 10, 20);
      chk("forced_ack", {31'd0, game_ack}, 32'd1);
      chk("forced_addr", {14'd0, rom_addr}, 32'd6410);
      gq.push_back({1'b0, romf(18'd6410)});
      step(1, 9, 0, 0, 0, 0);
      chk("displaced_vga_valid", {31'd0, vga_valid}, 32'd0);
      chk("displaced_vga_data", {27'd0, vga_data}, {27'd0, romf(18'd7)});
      chk("vga_addr_after_force", {14'd0, rom_addr}, 32'd9);
      vq.push_back(romf(18'd9));
      step(0, 0, 0, 0, 0, 0);

      // Back-to-back lookups: request held through the response cycle is not sampled
      step(0, 0, 0, 1, 1, 1);
      chk("b2b_ack1", {31'd0, game_ack}, 32'd1);
      chk("b2b_addr1", {14'd0, rom_addr}, 32'd321);
      gq.push_back({1'b0, romf(18'd321)});
      step(0, 0, 0, 1, 1, 1);
      chk("b2b_resp_no_ack", {31'd0, game_ack}, 32'd0);
      step(0, 0, 0, 1, 1, 1);
      chk("b2b_ack2", {31'd0, game_ack}, 32'd1);
      gq.push_back({1'b0, romf(18'd321)});
      step(0, 0, 0, 0, 0, 0);

      // Reset in the cycle after ack drops the in-flight response
      step(0, 0, 0, 1, 2, 2);
      chk("pre_reset_ack", {31'd0, game_ack}, 32'd1);
      chk("pre_reset_addr", {14'd0, rom_addr}, 32'd642);
      @(posedge Clk); #1;
      Reset_n = 1'b0; game_req = 1'b0;
      @(negedge Clk);
      chk("mid_reset_outputs", {vga_valid, vga_data, game_ack, game_valid, game_data, game_oob, rom_addr}, 32'd0);
      @(posedge Clk); #1 Reset_n = 1'b1;
      @(negedge Clk);
      chk("post_reset_no_valid", {31'd0, game_valid}, 32'd0);
      step(0, 0, 0, 1, 4, 0);
      chk("post_reset_ack", {31'd0, game_ack}, 32'd1);
      chk("post_reset_addr", {14'd0, rom_addr}, 32'd4);
      gq.push_back({1'b0, romf(18'd4)});
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      chk("vga_queue_drained", vq.size(), 32'd0);
      chk("game_queue_drained", gq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
